// File: rtl/tcp_vlg_tx_sched.sv
// TCP segment transmit scheduler: arbitrates data, FIN and delayed pure ACK onto the tx engine,
// pacing sends with a done-wait (with timeout) and an inter-send gap.
module tcp_vlg_tx_sched #(
  parameter int unsigned ACK_DELAY_TICKS = 100,
  parameter int unsigned DONE_TIMEOUT    = 4000,
  parameter int unsigned GAP_TICKS       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        connected,
  input  logic        data_pend,
  input  logic [31:0] data_seq,
  input  logic [15:0] data_len,
  input  logic [31:0] data_chsum,
  input  logic [31:0] loc_seq,
  input  logic        ack_req,
  input  logic        fin_req,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic        send,
  output logic [31:0] hdr_seq,
  output logic [15:0] hdr_len,
  output logic [31:0] hdr_chsum,
  output logic [2:0]  hdr_flags,
  output logic        fin_sent,
  output logic        tx_err
);

  localparam int unsigned WaitW      = (DONE_TIMEOUT > 0) ? $clog2(DONE_TIMEOUT + 1) : 1;
  localparam int unsigned GapLastInt = (GAP_TICKS > 1) ? GAP_TICKS - 1 : 0;
  localparam int unsigned GapW       = (GapLastInt > 0) ? $clog2(GapLastInt + 1) : 1;
  localparam logic [WaitW-1:0] DoneCnt = WaitW'(DONE_TIMEOUT);
  localparam logic [GapW-1:0]  GapLast = GapW'(GapLastInt);
  localparam logic [15:0]      AckMax  = 16'(ACK_DELAY_TICKS);

  typedef enum logic [1:0] {StIdle, StSend, StWait, StGap} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
  logic             ack_pend_q;
  logic [1:0]       ack_cnt_q;
  logic [15:0]      ack_tmr_q;
  logic             fin_sent_q;
  logic             ack_due, fin_elig, load;
  logic [31:0]      sel_seq;
  logic [15:0]      sel_len;
  logic [31:0]      sel_chsum;
  logic [2:0]       sel_flags;

  assign ack_due  = ack_pend_q && ((ack_tmr_q == AckMax) || (ack_cnt_q == 2'd2));
  assign fin_elig = fin_req && !data_pend && !fin_sent_q;
  assign fin_sent = fin_sent_q;

  // Fixed priority: data > FIN > pure ACK. Every segment carries ACK.
  always_comb begin
    sel_seq   = loc_seq;
    sel_len   = 16'd0;
    sel_chsum = 32'd0;
    sel_flags = 3'b001;
    if (data_pend) begin
      sel_seq   = data_seq;
      sel_len   = data_len;
      sel_chsum = data_chsum;
      sel_flags = 3'b011;
    end else if (fin_elig) begin
      sel_flags = 3'b101;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    send       = 1'b0;
    tx_err     = 1'b0;
    load       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (connected && !tx_busy && (data_pend || fin_elig || ack_due)) begin
          load    = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        send       = 1'b1;
        wait_cnt_d = WaitW'(1);
        state_d    = StWait;
      end
      StWait: begin
        if (tx_done) begin
          gap_cnt_d = '0;
          state_d   = StGap;
        end else if (wait_cnt_q == DoneCnt) begin
          tx_err    = 1'b1;
          gap_cnt_d = '0;
          state_d   = StGap;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) state_d = StIdle;
        else gap_cnt_d = gap_cnt_q + GapW'(1);
      end
      default: state_d = StIdle;
    endcase
    // Link loss aborts silently: nothing goes out, no error is raised.
    if (!connected) begin
      state_d = StIdle;
      send    = 1'b0;
      tx_err  = 1'b0;
    end
    if (rst) begin
      send   = 1'b0;
      tx_err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
      hdr_seq    <= '0;
      hdr_len    <= '0;
      hdr_chsum  <= '0;
      hdr_flags  <= '0;
      fin_sent_q <= 1'b0;
      ack_pend_q <= 1'b0;
      ack_cnt_q  <= '0;
      ack_tmr_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      if (load) begin
        hdr_seq   <= sel_seq;
        hdr_len   <= sel_len;
        hdr_chsum <= sel_chsum;
        hdr_flags <= sel_flags;
      end
      if (!connected) begin
        fin_sent_q <= 1'b0;
      end else if (state_q == StWait && tx_done && hdr_flags[2]) begin
        fin_sent_q <= 1'b1;
      end
      if (!connected) begin
        ack_pend_q <= 1'b0;
        ack_cnt_q  <= '0;
        ack_tmr_q  <= '0;
      end else if (send) begin
        // A request arriving with the send is not covered by it.
        ack_pend_q <= ack_req;
        ack_cnt_q  <= ack_req ? 2'd1 : 2'd0;
        ack_tmr_q  <= '0;
      end else if (ack_req) begin
        ack_pend_q <= 1'b1;
        ack_cnt_q  <= (ack_cnt_q == 2'd2) ? 2'd2 : ack_cnt_q + 2'd1;
        ack_tmr_q  <= '0;
      end else if (ack_pend_q && ack_tmr_q != AckMax) begin
        ack_tmr_q <= ack_tmr_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_tcp_vlg_tx_sched.sv
// Randomized bench for tcp_vlg_tx_sched against a timestamp-based reference model.
module tb_tcp_vlg_tx_sched;

  localparam int AckDelay  = 20;
  localparam int DoneTo    = 40;
  localparam int Gap       = 2;
  localparam int NumCycles = 20000;

  logic        clk = 1'b0;
  logic        rst, connected, data_pend, ack_req, fin_req, tx_busy, tx_done;
  logic [31:0] data_seq, data_chsum, loc_seq;
  logic [15:0] data_len;
  logic        send, fin_sent, tx_err;
  logic [31:0] hdr_seq, hdr_chsum;
  logic [15:0] hdr_len;
  logic [2:0]  hdr_flags;

  always #5 clk = ~clk;

  tcp_vlg_tx_sched #(
    .ACK_DELAY_TICKS(AckDelay),
    .DONE_TIMEOUT   (DoneTo),
    .GAP_TICKS      (Gap)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .connected (connected),
    .data_pend (data_pend),
    .data_seq  (data_seq),
    .data_len  (data_len),
    .data_chsum(data_chsum),
    .loc_seq   (loc_seq),
    .ack_req   (ack_req),
    .fin_req   (fin_req),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .send      (send),
    .hdr_seq   (hdr_seq),
    .hdr_len   (hdr_len),
    .hdr_chsum (hdr_chsum),
    .hdr_flags (hdr_flags),
    .fin_sent  (fin_sent),
    .tx_err    (tx_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: scheduler phases are tracked as cycle timestamps, ACK debt as a count
  // plus the cycle of the most recent request.
  int          send_at    = -1;  // cycle in which a send pulse is due
  int          wait_since = -1;  // cycle of the send being waited on
  int          gap_until  = 0;   // first cycle the scheduler may pick again
  int          ack_count  = 0;
  int          last_req   = 0;
  bit          fin_sent_m = 1'b0;
  logic [82:0] hdr_m      = '0;  // {seq, len, chsum, flags}
  int          done_at    = -1;
  int          disc_left  = 0;
  int          n_sends = 0, n_errs = 0, n_fins = 0, n_pure = 0;

  task automatic drive(input int n);
    rst = (n < 3) || ($urandom_range(0, 2999) == 0);
    if (disc_left > 0) begin
      disc_left--;
      connected = 1'b0;
    end else if ($urandom_range(0, 399) == 0) begin
      disc_left = $urandom_range(0, 4);
      connected = 1'b0;
    end else begin
      connected = 1'b1;
    end
    if (!connected) fin_req = 1'b0;
    else if ($urandom_range(0, 299) == 0) fin_req = 1'b1;
    if (!data_pend && $urandom_range(0, 39) == 0) begin
      data_pend  = 1'b1;
      data_seq   = $urandom;
      data_len   = 16'($urandom);
      data_chsum = $urandom;
    end else if (data_pend && $urandom_range(0, 14) == 0) begin
      data_pend = 1'b0;
    end
    if ($urandom_range(0, 49) == 0) loc_seq = $urandom;
    ack_req = ($urandom_range(0, 11) == 0);
    tx_busy = ($urandom_range(0, 4) == 0);
    tx_done = (n == done_at);
  endtask

  task automatic evaluate(input int n);
    bit exp_send, exp_err, due, dly;
    dly      = (n - last_req - 1) >= AckDelay;
    due      = (ack_count > 0) && (dly || ack_count >= 2);
    exp_send = !rst && connected && (send_at == n);
    exp_err  = !rst && connected && (wait_since >= 0) && !tx_done && (n - wait_since == DoneTo);
    check("send", {127'd0, send}, {127'd0, exp_send});
    check("tx_err", {127'd0, tx_err}, {127'd0, exp_err});
    check("fin_sent", {127'd0, fin_sent}, {127'd0, fin_sent_m});
    check("hdr", {45'd0, hdr_seq, hdr_len, hdr_chsum, hdr_flags}, {45'd0, hdr_m});
    if (exp_send) begin
      n_sends++;
      if ($urandom_range(0, 9) == 0) done_at = -1;
      else done_at = n + $urandom_range(1, 12);
    end
    if (exp_err) n_errs++;

    if (rst) begin
      send_at = -1; wait_since = -1; gap_until = 0;
      ack_count = 0; fin_sent_m = 1'b0; hdr_m = '0;
    end else if (!connected) begin
      send_at = -1; wait_since = -1; gap_until = 0;
      ack_count = 0; fin_sent_m = 1'b0;
    end else begin
      if (send_at == n) begin
        send_at    = -1;
        wait_since = n;
        ack_count  = ack_req ? 1 : 0;
        last_req   = n;
      end else begin
        if (ack_req) begin
          ack_count++;
          last_req = n;
        end
        if (wait_since >= 0) begin
          if (tx_done || (n - wait_since == DoneTo)) begin
            if (tx_done && hdr_m[2]) begin
              fin_sent_m = 1'b1;
              n_fins++;
            end
            wait_since = -1;
            gap_until  = n + 1 + Gap;
          end
        end else if (send_at < 0 && n >= gap_until && !tx_busy) begin
          if (data_pend) begin
            hdr_m   = {data_seq, data_len, data_chsum, 3'b011};
            send_at = n + 1;
          end else if (fin_req && !fin_sent_m) begin
            hdr_m   = {loc_seq, 16'd0, 32'd0, 3'b101};
            send_at = n + 1;
          end else if (due) begin
            hdr_m   = {loc_seq, 16'd0, 32'd0, 3'b001};
            send_at = n + 1;
            n_pure++;
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; connected = 1'b0; data_pend = 1'b0; ack_req = 1'b0; fin_req = 1'b0;
    tx_busy = 1'b0; tx_done = 1'b0; data_seq = '0; data_len = '0; data_chsum = '0;
    loc_seq = 32'h1000;
    for (int n = 0; n < NumCycles; n++) begin
      @(posedge clk);
      #1;
      drive(n);
      @(negedge clk);
      evaluate(n);
    end
    // Stimulus must have reached every kind of outcome for the checks above to mean much.
    check("cov_sends", {127'd0, n_sends > 100}, 128'd1);
    check("cov_tx_err", {127'd0, n_errs > 0}, 128'd1);
    check("cov_fin_done", {127'd0, n_fins > 0}, 128'd1);
    check("cov_pure_ack", {127'd0, n_pure > 0}, 128'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tcp_vlg_tx_sched.md
TCP_VLG_TX_SCHED -- requirements
Module: tcp_vlg_tx_sched

Interface
REQ-001 SHALL have parameter ACK_DELAY_TICKS, default 100: delayed-ACK timeout in clk cycles.
REQ-002 SHALL have parameter DONE_TIMEOUT, default 4000: maximum cycles to wait for tx_done.
REQ-003 SHALL have parameter GAP_TICKS, default 2: idle cycles between consecutive sends.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 connected  in  1  TCP connection established (level).
REQ-007 data_pend  in  1  data queue has a packet ready to (re)transmit (level).
REQ-008 data_seq  in  32  seq of the pending data packet.
REQ-009 data_len  in  16  payload length of the pending data packet.
REQ-010 data_chsum  in  32  payload checksum of the pending data packet.
REQ-011 loc_seq  in  32  current local seq for control-only segments.
REQ-012 ack_req  in  1  one-cycle pulse: received segment requires acknowledgment.
REQ-013 fin_req  in  1  close requested (level).
REQ-014 tx_busy  in  1  TCP tx engine busy.
REQ-015 tx_done  in  1  one-cycle pulse: TCP tx engine finished a segment.
REQ-016 send  out  1  one-cycle pulse: start segment with hdr_* fields.
REQ-017 hdr_seq  out  32  seq for the segment.
REQ-018 hdr_len  out  16  payload length (0 for control-only).
REQ-019 hdr_chsum  out  32  payload checksum (0 for control-only).
REQ-020 hdr_flags  out  3  [2] FIN, [1] PSH, [0] ACK.
REQ-021 fin_sent  out  1  sticky: FIN segment completed.
REQ-022 tx_err  out  1  one-cycle pulse: tx_done timeout.

Function
REQ-023 FSM states: IDLE, SEND, WAIT, GAP.
REQ-024 IDLE -> SEND when connected && !tx_busy && a request is eligible; request latched into hdr_* at this transition.
REQ-025 Priority, fixed: data (data_pend) > FIN (fin_req && !data_pend && !fin_sent) > pure ACK (ack_due).
REQ-026 Data segment: hdr_seq=data_seq, hdr_len=data_len, hdr_chsum=data_chsum, hdr_flags=3'b011.
REQ-027 FIN segment: hdr_seq=loc_seq, hdr_len=0, hdr_chsum=0, hdr_flags=3'b101.
REQ-028 Pure ACK: hdr_seq=loc_seq, hdr_len=0, hdr_chsum=0, hdr_flags=3'b001.
REQ-029 SEND: assert send exactly one cycle, go to WAIT; hdr_* stable from SEND until leaving WAIT.
REQ-030 WAIT -> GAP on tx_done; WAIT -> GAP with tx_err pulse when wait counter reaches DONE_TIMEOUT.
REQ-031 GAP lasts GAP_TICKS cycles, then IDLE.
REQ-032 Delayed ACK: ack_req sets ack_pend and clears 16-bit ack timer; timer increments while ack_pend, saturates at ACK_DELAY_TICKS.
REQ-033 ack_due = ack_pend && (timer == ACK_DELAY_TICKS || ack_cnt == 2); ack_cnt counts ack_req pulses since last ACK-carrying send, saturating at 2.
REQ-034 Any send with ACK flag clears ack_pend, ack_cnt and timer in the SEND cycle; an ack_req in that same cycle re-sets ack_pend with ack_cnt=1.
REQ-035 fin_sent set on tx_done (not timeout) of a FIN segment; cleared only by reset or connected falling.
REQ-036 connected low in SEND/WAIT/GAP: abort to IDLE next cycle, no send, no tx_err; ack_pend, ack_cnt, timer, fin_sent cleared.
REQ-037 Requests seen while not IDLE are not lost: data_pend/fin_req are levels; ack_pend persists.
REQ-038 Wait counter width sufficient for DONE_TIMEOUT, no wrap.

Reset
REQ-039 On rst: FSM=IDLE; send=0, tx_err=0, fin_sent=0, hdr_seq=0, hdr_len=0, hdr_chsum=0, hdr_flags=0; ack_pend, ack_cnt, timers cleared.
REQ-040 rst mid-WAIT: outputs at reset values next cycle; later tx_done ignored.

Verification
REQ-041 data_pend=1, data_seq=0x1000, len=100, chsum=0xABCD, connected=1 -> send pulse 1 cycle after, hdr_flags=3'b011; tx_done -> IDLE after GAP_TICKS.
REQ-042 single ack_req, no data -> pure ACK send ACK_DELAY_TICKS(+1) cycles later, hdr_seq=loc_seq, len=0.
REQ-043 two ack_req 5 cycles apart -> pure ACK sent immediately after second, before timer expiry.
REQ-044 data_pend and fin_req and ack_due simultaneously -> data first, then FIN; no separate pure ACK; fin_sent=1 after FIN tx_done.
REQ-045 send with tx_done never returned -> tx_err pulse after DONE_TIMEOUT cycles, FSM returns to IDLE.
REQ-046 connected dropped in WAIT -> IDLE next cycle, no tx_err, fin_sent=0, no further send.
